// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bus bundle between the decode/writeback stages and the multi-port
// register file. Addresses and data are packed per port.
//
// Signals:
//   clr          soft clear request (decode side -> register file)
//   rd_addr      NRD packed read addresses, port i at [i*AW +: AW]
//   rd_data      NRD packed read data, port i at [i*XLEN +: XLEN]
//   wr_en        per-port write enable
//   wr_addr      NWR packed write addresses
//   wr_data      NWR packed write data
//   busy         high while the clear sequencer is running
//   wr_conflict  one-cycle pulse after a write-write collision
//
// Modports:
//   master  the datapath side that issues reads and writes
//   slave   the register file
interface regfile_mp_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS),
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    logic                clr;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic                busy;
    logic                wr_conflict;

    modport master (
        output clr, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, busy, wr_conflict
    );

    modport slave (
        input  clr, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, busy, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised multi-port integer register file for the dual-issue datapath.
// NRD combinational read ports, NWR synchronous write ports, optional
// same-cycle write-to-read bypass and an optional hardwired zero register.
// A clear sequencer zeroes one register per clock after reset or after a
// soft-clear request; while it runs the file reports busy and reads as 0.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous reset, active-high
//   bus   regfile_mp_if slave modport (clr, read/write ports, busy,
//         wr_conflict)
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = $clog2(NREGS),
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state;
    state_t          next_state;
    logic [AW-1:0]   clr_idx;
    logic            busy_q;
    logic            conflict_q;
    logic            conflict_now;
    logic            clr_we;
    logic [NWR-1:0]  wr_vld;
    logic [NWR-1:0]  wr_go;

    logic [XLEN-1:0] mem [NREGS];
    logic [AW-1:0]   wa  [NWR];
    logic [XLEN-1:0] wd  [NWR];
    logic [AW-1:0]   ra  [NRD];
    logic [XLEN-1:0] rd  [NRD];

    // Split the packed port buses into per-port arrays.
    always_comb begin
        for (int j = 0; j < NWR; j++) begin
            wa[j] = bus.wr_addr[j*AW +: AW];
            wd[j] = bus.wr_data[j*XLEN +: XLEN];
        end
        for (int i = 0; i < NRD; i++) begin
            ra[i] = bus.rd_addr[i*AW +: AW];
        end
    end

    // State register. busy is a flop that tracks the next state so it
    // rises with reset/clr and falls on the edge that writes the last index.
    // clr_idx only advances in CLEAR and wraps naturally since NREGS is a
    // power of two; in READY it is held at 0 ready for the next clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
        end else begin
            state   <= next_state;
            busy_q  <= (next_state == CLEAR);
            clr_idx <= (state == CLEAR) ? clr_idx + AW'(1) : '0;
        end
    end

    // Next-state logic: clr is only honoured in READY.
    always_comb begin
        next_state = state;
        case (state)
            CLEAR: if (clr_idx == AW'(NREGS - 1)) next_state = READY;
            READY: if (bus.clr) next_state = CLEAR;
        endcase
    end

    // Output/control logic. wr_vld marks a write that is architecturally
    // real this cycle (drives bypass); wr_go additionally drops writes that
    // coincide with a soft-clear request, since the file is about to be wiped.
    always_comb begin
        clr_we = (state == CLEAR);
        wr_vld = '0;
        wr_go  = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_vld[j] = (state == READY) && bus.wr_en[j]
                        && !(ZERO_REG && (wa[j] == '0));
            wr_go[j]  = wr_vld[j] && !bus.clr;
        end
    end

    // A collision needs two ports, so single-write configurations tie it off.
    generate
        if (NWR == 2) begin : g_conflict
            assign conflict_now = wr_go[0] && wr_go[1] && (wa[0] == wa[1]);
        end else begin : g_no_conflict
            assign conflict_now = 1'b0;
        end
    endgenerate

    // wr_conflict is a registered pulse for the cycle after the collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_q <= 1'b0;
        end else begin
            conflict_q <= conflict_now;
        end
    end

    // Array write. The clear sequencer takes the write port ahead of the
    // normal ports; among normal ports the later loop iteration wins, which
    // gives the higher-index port priority on a collision.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (!rst) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_go[j]) begin
                    mem[wa[j]] <= wd[j];
                end
            end
        end
    end

    // Combinational read with bypass. Scanning ports in ascending order lets
    // the higher-index port override, matching the write priority. The zero
    // register and the busy blanking override everything else.
    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd[i] = mem[ra[i]];
            if (BYPASS) begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_vld[j] && (wa[j] == ra[i])) begin
                        rd[i] = wd[j];
                    end
                end
            end
            if (ZERO_REG && (ra[i] == '0)) begin
                rd[i] = '0;
            end
            if (busy_q) begin
                rd[i] = '0;
            end
        end
    end

    // Repack read data onto the bus.
    always_comb begin
        bus.rd_data = '0;
        for (int i = 0; i < NRD; i++) begin
            bus.rd_data[i*XLEN +: XLEN] = rd[i];
        end
    end

    assign bus.busy        = busy_q;
    assign bus.wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances share one stimulus stream:
// dut_a (NRD=4, BYPASS=1) is checked on all read ports, busy and
// wr_conflict; dut_b (BYPASS=0) is checked on read port 0 only, to show
// the pre-edge array value. Each stimulus cycle pushes its hand-computed
// expectation into a queue that a monitor pops on the falling edge.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int NRD   = 4;
    localparam int NWR   = 2;

    typedef struct packed {
        logic [6:0]   chk;
        logic [127:0] rd;
        logic         busy;
        logic         conf;
        logic [31:0]  nb;
        logic [63:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;
    exp_t sb_q [$];

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_a ();
    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_b ();

    assign bus_b.clr     = bus_a.clr;
    assign bus_b.rd_addr = bus_a.rd_addr;
    assign bus_b.wr_en   = bus_a.wr_en;
    assign bus_b.wr_addr = bus_a.wr_addr;
    assign bus_b.wr_data = bus_a.wr_data;

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(1'b1), .BYPASS(1'b1)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a.slave)
    );

    regfile_mp #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR),
        .ZERO_REG(1'b1), .BYPASS(1'b0)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ra4(input logic [4:0] a0, input logic [4:0] a1,
                                        input logic [4:0] a2, input logic [4:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    function automatic logic [127:0] d4(input logic [31:0] d0, input logic [31:0] d1,
                                        input logic [31:0] d2, input logic [31:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    // Build an expectation: rd mask selects checked ports of dut_a; busy and
    // wr_conflict are always checked when chk_all is set.
    function automatic exp_t mk(input logic [63:0] tag, input logic chk_all,
                                input logic [3:0] mask, input logic [127:0] rd,
                                input logic b, input logic cf,
                                input logic chk_nb, input logic [31:0] nb);
        exp_t e;
        e.chk  = {chk_nb, chk_all, chk_all, mask};
        e.rd   = rd;
        e.busy = b;
        e.conf = cf;
        e.nb   = nb;
        e.tag  = tag;
        return e;
    endfunction

    // Drive one cycle of inputs just after the rising edge and queue the
    // response expected before the next rising edge.
    task automatic apply_stimulus(input logic r, input logic c, input logic [1:0] we,
                                  input logic [4:0] wa0, input logic [31:0] wd0,
                                  input logic [4:0] wa1, input logic [31:0] wd1,
                                  input logic [19:0] ra, input exp_t e);
        @(posedge clk);
        #1;
        rst           = r;
        bus_a.clr     = c;
        bus_a.wr_en   = we;
        bus_a.wr_addr = {wa1, wa0};
        bus_a.wr_data = {wd1, wd0};
        bus_a.rd_addr = ra;
        sb_q.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        for (int i = 0; i < 4; i++) begin
            if (e.chk[i]) begin
                vectors++;
                if (bus_a.rd_data[i*32 +: 32] !== e.rd[i*32 +: 32]) begin
                    miscompares++;
                    $display("[TB] FAIL %s rd_data%0d: got %h expected %h",
                             e.tag, i, bus_a.rd_data[i*32 +: 32], e.rd[i*32 +: 32]);
                end
            end
        end
        if (e.chk[4]) begin
            vectors++;
            if (bus_a.busy !== e.busy) begin
                miscompares++;
                $display("[TB] FAIL %s busy: got %b expected %b", e.tag, bus_a.busy, e.busy);
            end
        end
        if (e.chk[5]) begin
            vectors++;
            if (bus_a.wr_conflict !== e.conf) begin
                miscompares++;
                $display("[TB] FAIL %s wr_conflict: got %b expected %b",
                         e.tag, bus_a.wr_conflict, e.conf);
            end
        end
        if (e.chk[6]) begin
            vectors++;
            if (bus_b.rd_data[31:0] !== e.nb) begin
                miscompares++;
                $display("[TB] FAIL %s nobypass rd_data0: got %h expected %h",
                         e.tag, bus_b.rd_data[31:0], e.nb);
            end
        end
    endtask

    // Monitor: compare the DUT outputs against the oldest queued expectation
    // on every falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output(e);
            end
        end
    end

    // Directed stimulus.
    initial begin
        logic        b;
        vectors       = 0;
        miscompares   = 0;
        rst           = 1'b1;
        bus_a.clr     = 1'b0;
        bus_a.wr_en   = '0;
        bus_a.wr_addr = '0;
        bus_a.wr_data = '0;
        bus_a.rd_addr = '0;

        // Two reset cycles; the second one already sees the reset state.
        apply_stimulus(1, 0, 2'b00, 0, 0, 0, 0, ra4(0, 0, 0, 0),
                       mk("rst0", 0, 4'h0, '0, 0, 0, 0, 0));
        apply_stimulus(1, 0, 2'b00, 0, 0, 0, 0, ra4(0, 0, 0, 0),
                       mk("rst1", 1, 4'h0, '0, 1, 0, 0, 0));

        // Clear sequence: busy for exactly 32 cycles. Writes, a collision
        // and a clr request issued meanwhile must all be ignored.
        for (int k = 0; k < 34; k++) begin
            b = (k < 32);
            apply_stimulus(0, (k == 10),
                           (k == 5) ? 2'b01 : ((k == 7) ? 2'b11 : 2'b00),
                           (k == 7) ? 5'd6 : 5'd5, (k == 7) ? 32'h1 : 32'hDEADBEEF,
                           5'd6, 32'h2, ra4(5, 6, 5, 6),
                           mk("clrseq", 1, 4'hF, '0, b, 0, 1, 0));
        end

        // Every register reads zero after the clear.
        for (int g = 0; g < 8; g++) begin
            apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0,
                           ra4(5'(4*g), 5'(4*g+1), 5'(4*g+2), 5'(4*g+3)),
                           mk("allzero", 1, 4'hF, '0, 0, 0, 1, 0));
        end

        // Basic write with same-cycle bypass, then normal read.
        apply_stimulus(0, 0, 2'b01, 7, 32'h12345678, 0, 0, ra4(7, 0, 0, 0),
                       mk("byp_wr", 1, 4'h1, d4(32'h12345678, 0, 0, 0), 0, 0, 1, 0));
        apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(7, 7, 0, 0),
                       mk("rd_x7", 1, 4'h3, d4(32'h12345678, 32'h12345678, 0, 0),
                          0, 0, 1, 32'h12345678));

        // Zero register on both ports: stays zero, no collision.
        apply_stimulus(0, 0, 2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, ra4(0, 0, 0, 0),
                       mk("x0_wr", 1, 4'hF, '0, 0, 0, 1, 0));
        apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(0, 0, 0, 0),
                       mk("x0_rd", 1, 4'hF, '0, 0, 0, 1, 0));

        // Collision on x3: port 1 wins in bypass and in the array.
        apply_stimulus(0, 0, 2'b11, 3, 32'hAAAA0000, 3, 32'h5555FFFF, ra4(3, 0, 0, 0),
                       mk("coll_wr", 1, 4'h1, d4(32'h5555FFFF, 0, 0, 0), 0, 0, 1, 0));
        // Conflict pulse plus disjoint dual write x4/x9 with bypass.
        apply_stimulus(0, 0, 2'b11, 4, 32'h44444444, 9, 32'h99999999, ra4(3, 4, 9, 3),
                       mk("coll_rd", 1, 4'hF,
                          d4(32'h5555FFFF, 32'h44444444, 32'h99999999, 32'h5555FFFF),
                          0, 1, 1, 32'h5555FFFF));
        apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(4, 9, 3, 0),
                       mk("disjoint", 1, 4'hF,
                          d4(32'h44444444, 32'h99999999, 32'h5555FFFF, 0),
                          0, 0, 1, 32'h44444444));

        // Read fan-out: all four ports on x12, bypassed from port 1 first.
        apply_stimulus(0, 0, 2'b10, 0, 0, 12, 32'hCAFEF00D, ra4(12, 12, 12, 12),
                       mk("fan_byp", 1, 4'hF,
                          d4(32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D),
                          0, 0, 1, 0));
        apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(12, 12, 12, 12),
                       mk("fan_rd", 1, 4'hF,
                          d4(32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D),
                          0, 0, 1, 32'hCAFEF00D));

        // Soft clear: x10 stored, then clr with a write to x11 that is dropped.
        apply_stimulus(0, 0, 2'b01, 10, 32'h1, 0, 0, ra4(10, 0, 0, 0),
                       mk("x10_wr", 1, 4'h1, d4(32'h1, 0, 0, 0), 0, 0, 1, 0));
        apply_stimulus(0, 1, 2'b01, 11, 32'h77, 0, 0, ra4(10, 0, 0, 0),
                       mk("clr_req", 1, 4'h1, d4(32'h1, 0, 0, 0), 0, 0, 1, 32'h1));
        for (int k = 0; k < 33; k++) begin
            b = (k < 32);
            apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(10, 11, 0, 0),
                           mk("softclr", 1, 4'h3, '0, b, 0, 1, 0));
        end

        // Reset while clr_idx is 15: the sequence restarts for 32 more cycles.
        apply_stimulus(0, 0, 2'b01, 13, 32'h13, 0, 0, ra4(13, 0, 0, 0),
                       mk("x13_wr", 1, 4'h1, d4(32'h13, 0, 0, 0), 0, 0, 1, 0));
        apply_stimulus(0, 1, 2'b00, 0, 0, 0, 0, ra4(13, 0, 0, 0),
                       mk("clr_req2", 1, 4'h1, d4(32'h13, 0, 0, 0), 0, 0, 1, 32'h13));
        for (int k = 0; k < 16; k++) begin
            apply_stimulus((k == 15), 0, 2'b00, 0, 0, 0, 0, ra4(13, 0, 0, 0),
                           mk("midclr", 1, 4'h1, '0, 1, 0, 1, 0));
        end
        for (int k = 0; k < 33; k++) begin
            b = (k < 32);
            apply_stimulus(0, 0, 2'b00, 0, 0, 0, 0, ra4(13, 0, 0, 0),
                           mk("restart", 1, 4'h1, '0, b, 0, 1, 0));
        end

        // Let the monitor drain the last expectation.
        @(negedge clk);
        #1;
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file; successor to the single-write/dual-read core register file.
- Serves the dual-issue datapath: NRD combinational read ports and NWR synchronous write ports, with an optional same-cycle write-to-read bypass.
- Contents are initialised by a hardware clear sequencer after reset or on a soft-clear request. There is no file preload.
- Sits between decode (reads) and writeback (writes).

Parameters:
- XLEN, 32, register data width in bits.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), address width (derived; do not override).
- NRD, 2, number of read ports, 1..4.
- NWR, 2, number of write ports, 1..2.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.
- BYPASS, 1, when 1 a read of an address being written this cycle returns the write data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- clr  in  1  soft clear request, sampled in READY only.
- rd_addr  in  NRD*AW  packed read addresses; port i is bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  packed read data; port i is bits [i*XLEN +: XLEN].
- wr_en  in  NWR  per-port write enable.
- wr_addr  in  NWR*AW  packed write addresses.
- wr_data  in  NWR*XLEN  packed write data.
- busy  out  1  high while the clear sequencer runs.
- wr_conflict  out  1  registered pulse flagging a write-write collision.

Behaviour:
- FSM states:
  - CLEAR: clr_idx walks 0..NREGS-1 and writes zero to array[clr_idx], one register per clock.
  - READY: normal operation.
- Reset (rst=1 at a posedge): state<=CLEAR, clr_idx<=0, busy<=1, wr_conflict<=0. Array contents are not directly reset.
- Reset mid-CLEAR or mid-READY: the sequence restarts from index 0.
- CLEAR -> READY on the posedge at which clr_idx==NREGS-1 is written.
  - busy is therefore high for exactly NREGS cycles after the first non-reset edge.
  - busy is registered and falls on the same edge as the transition.
- READY -> CLEAR at a posedge with clr=1 and rst=0; clr_idx<=0, busy<=1.
  - Writes presented in that same cycle are discarded.
- While busy=1:
  - wr_en is ignored.
  - All rd_data return 0.
  - clr is ignored.
  - wr_conflict stays 0.
- Write, READY only: on a posedge, for each port j with wr_en[j]=1, array[wr_addr[j]]<=wr_data[j].
  - If ZERO_REG=1 and wr_addr[j]==0, the write is dropped.
  - Data is visible to a non-bypassed read from the next cycle.
- Write collision: both ports enabled, same address, address not a dropped zero-register write.
  - Port NWR-1 (the higher index) wins.
  - wr_conflict=1 for exactly the following cycle; otherwise wr_conflict=0.
- Read is combinational, zero latency: rd_data[i] = array[rd_addr[i]].
  - ZERO_REG=1 and rd_addr[i]==0 -> 0 regardless of array content.
- Bypass (BYPASS=1, READY): if some wr_en[j]=1 with wr_addr[j]==rd_addr[i] (and not a dropped zero-register write), rd_data[i]=wr_data[j].
  - With two matching ports, the higher-index port's data is returned, consistent with the write priority.
  - BYPASS=0: rd_data reflects the pre-edge array content.
- Multiple read ports may address the same register; each returns identical data.
- NWR=1: wr_conflict is tied 0.
- Array is inferable as distributed RAM plus bypass muxes. The clear sequencer drives the array's write port through a mux ahead of the normal write ports.

Test Plan:
1. Clear sequence: rst high for 2 cycles then low, NREGS=32 -> busy=1 for exactly 32 cycles then 0. Every register then reads 0. A write of 0xDEADBEEF to x5 issued during busy is absent afterwards (x5 reads 0).
2. Basic write/read: READY; write x7=0x12345678 via port 0. Next cycle rd_addr0=7 -> 0x12345678. With BYPASS=1, the same-cycle read returns 0x12345678. With BYPASS=0 it returns the old value 0.
3. Zero register: write x0=0xFFFFFFFF on both ports -> rd_data for address 0 is 0. wr_conflict stays 0.
4. Dual write collision: port0 x3=0xAAAA0000, port1 x3=0x5555FFFF in the same cycle. The same-cycle bypass read returns 0x5555FFFF. The next cycle x3 reads 0x5555FFFF and wr_conflict=1 for one cycle. Disjoint dual writes x4/x9 both land and wr_conflict=0.
5. Soft clear and mid-sequence reset: with x10=0x1 stored, pulse clr -> busy=1 for 32 cycles and x10 reads 0 afterwards. Assert rst at clr_idx=15 -> busy stays 1 and completes 32 further cycles after rst falls.
6. Read fan-out: NRD=4, all four ports address x12=0xCAFEF00D -> all four rd_data equal 0xCAFEF00D in the same cycle.
